pipelined_shifter: RTL

//  Parametrised, pipelined barrel shifter for the processor ALU: SLL/SRL/SRA (ROR optional) by any amount.

---
 rtl/pipelined_shifter_pkg.sv | 13 +
 rtl/pipelined_shifter_if.sv | 29 ++
 rtl/pipelined_shifter_shift_stage.sv | 40 ++++
 rtl/pipelined_shifter.sv | 85 ++++++++
 4 files changed

// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the operation field width. Imported by the interface, the per-stage
// shifter and the pipeline top.
package pipelined_shifter_pkg;

  localparam int SHIFT_OPW = 2;

  localparam logic [SHIFT_OPW-1:0] SHIFT_SLL = 2'b00;
  localparam logic [SHIFT_OPW-1:0] SHIFT_SRL = 2'b01;
  localparam logic [SHIFT_OPW-1:0] SHIFT_SRA = 2'b10;
  localparam logic [SHIFT_OPW-1:0] SHIFT_ROR = 2'b11;

endpackage

// File: rtl/pipelined_shifter_if.sv
// Request/response bundle of the pipelined shifter. The master side issues
// shift requests and consumes results; the slave side is the shifter.
interface pipelined_shifter_if
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);

  logic                 in_valid;
  logic                 in_ready;
  logic [SHIFT_OPW-1:0] in_op;
  logic [SHW-1:0]       in_shamt;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;

  modport master (
    output in_valid, in_op, in_shamt, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_shamt, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipelined_shifter_shift_stage.sv
// One conditional-shift stage of the barrel shifter: shifts by the fixed
// amount AMT when en is set, using the fill rule of the operation. The
// arithmetic fill comes from the operand sign captured at the first stage,
// because intermediate stages no longer see the original MSB.
// Optional feature macro: SHIFTER_ROTATE_EN (op 11 rotates right; when it is
// not defined op 11 is a logical right shift and no wrap path exists).
module shift_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [SHIFT_OPW-1:0] op,
  input  logic                 sign,
  input  logic                 en,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout
);

  // Select the shifted or pass-through operand with the op-specific fill.
  always_comb begin
    dout = din;
    if (en) begin
      case (op)
        SHIFT_SLL: dout = {din[WIDTH-1-AMT:0], {AMT{1'b0}}};
        SHIFT_SRL: dout = {{AMT{1'b0}}, din[WIDTH-1:AMT]};
        SHIFT_SRA: dout = {{AMT{sign}}, din[WIDTH-1:AMT]};
        SHIFT_ROR: begin
`ifdef SHIFTER_ROTATE_EN
          dout = {din[AMT-1:0], din[WIDTH-1:AMT]};
`else
          dout = {{AMT{1'b0}}, din[WIDTH-1:AMT]};
`endif
        end
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter for the ALU: SLL/SRL/SRA (and ROR when
// SHIFTER_ROTATE_EN is defined) by any amount 0..WIDTH-1. Stage k shifts by
// 2^k when its shift-amount bit is set; every stage has one register, so the
// result appears SHW cycles after acceptance. All stages advance together and
// the whole pipe stalls when the result is not taken. Bubbles are kept.
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  pipelined_shifter_if.slave bus,
  output logic               busy
);

  logic                 advance;
  logic                 vld_p   [SHW];
  logic [WIDTH-1:0]     data_p  [SHW];
  logic [SHIFT_OPW-1:0] op_p    [SHW];
  logic                 sign_p  [SHW];
  logic [SHW-1:0]       shamt_p [SHW];
  logic [WIDTH-1:0]     st_dout [SHW];

  assign advance       = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p[SHW-1];
  assign bus.out_data  = data_p[SHW-1];

  // Busy whenever any stage carries a live entry.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < SHW; i++) busy = busy | vld_p[i];
  end

  // The remaining shift amount is kept right-aligned, so every stage looks
  // at bit 0 of what it receives and hands the rest on shifted down by one.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_head
      shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_shift (
        .op   (bus.in_op),
        .sign (bus.in_data[WIDTH-1]),
        .en   (bus.in_shamt[0]),
        .din  (bus.in_data),
        .dout (st_dout[k])
      );
    end else begin : g_body
      shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_shift (
        .op   (op_p[k-1]),
        .sign (sign_p[k-1]),
        .en   (shamt_p[k-1][0]),
        .din  (data_p[k-1]),
        .dout (st_dout[k])
      );
    end
  end

  // Stage registers: all load together on advance, otherwise all hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SHW; k++) begin
        vld_p[k]   <= 1'b0;
        data_p[k]  <= '0;
        op_p[k]    <= '0;
        sign_p[k]  <= 1'b0;
        shamt_p[k] <= '0;
      end
    end else if (advance) begin
      vld_p[0]   <= bus.in_valid;
      data_p[0]  <= st_dout[0];
      op_p[0]    <= bus.in_op;
      sign_p[0]  <= bus.in_data[WIDTH-1];
      shamt_p[0] <= bus.in_shamt >> 1;
      for (int k = 1; k < SHW; k++) begin
        vld_p[k]   <= vld_p[k-1];
        data_p[k]  <= st_dout[k];
        op_p[k]    <= op_p[k-1];
        sign_p[k]  <= sign_p[k-1];
        shamt_p[k] <= shamt_p[k-1] >> 1;
      end
    end
  end

endmodule
